router_iact: RTL and testbench

ROUTER_IACT -- requirements
Module: router_iact

---
 rtl/router_iact.sv | 80 ++++++++
 tb/tb_router_iact.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/router_iact.sv
// Activation router: streams one act_size*act_size burst from the GLB into the PE scratchpads.
// state | meaning
// IDLE  | no burst in flight, waiting for load_spad_ctrl
// READ  | issuing one GLB read per cycle, addresses A_READ_ADDR upward
module router_iact #(
  parameter int DATA_BITWIDTH      = 16,
  parameter int ADDR_BITWIDTH_GLB  = 10,
  parameter int ADDR_BITWIDTH_SPAD = 9,
  parameter int kernel_size        = 3,
  parameter int act_size           = 5,
  parameter int A_READ_ADDR        = 0,
  parameter int A_LOAD_ADDR        = 100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_spad_ctrl,
  input  logic [DATA_BITWIDTH-1:0]     r_data_glb_iact,
  output logic                         read_req_glb_iact,
  output logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb_iact,
  output logic [DATA_BITWIDTH-1:0]     w_data_spad,
  output logic                         load_en_spad
);

  localparam int BURST_LEN = act_size * act_size;
  localparam int CNT_W     = $clog2(BURST_LEN + 1);

  localparam logic [CNT_W-1:0]             LAST_IDX  = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_BITWIDTH_GLB-1:0] BASE_ADDR = ADDR_BITWIDTH_GLB'(A_READ_ADDR);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  // Integration-only parameters are sanity-checked at elaboration.
  if (kernel_size < 1 || act_size < 1 || ADDR_BITWIDTH_SPAD < 1 || A_LOAD_ADDR < 0) begin : g_bad_param
    $error("router_iact: invalid parameter set");
  end

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      read_req_glb_iact <= 1'b0;
      r_addr_glb_iact   <= '0;
      load_en_spad      <= 1'b0;
    end else begin
      load_en_spad <= read_req_glb_iact;
      case (state)
        IDLE: begin
          if (load_spad_ctrl) begin
            state             <= READ;
            cnt               <= '0;
            read_req_glb_iact <= 1'b1;
            r_addr_glb_iact   <= BASE_ADDR;
          end
        end
        READ: begin
          // cnt tracks the index of the request currently on the bus.
          if (cnt == LAST_IDX) begin
            state             <= IDLE;
            read_req_glb_iact <= 1'b0;
          end else begin
            cnt               <= cnt + 1'b1;
            read_req_glb_iact <= 1'b1;
            r_addr_glb_iact   <= r_addr_glb_iact + 1'b1;
          end
        end
        default: begin
          state             <= IDLE;
          read_req_glb_iact <= 1'b0;
        end
      endcase
    end
  end

  assign w_data_spad = load_en_spad ? r_data_glb_iact : '0;

endmodule

// File: tb/tb_router_iact.sv
// Directed bench for router_iact: a plain-origin instance and a wrap-around instance (base 1020).
module tb_router_iact;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        load_a, load_b;
  logic [15:0] rdata_a, rdata_b, wd_a, wd_b;
  logic        rq_a, rq_b, le_a, le_b;
  logic [9:0]  ad_a, ad_b;

  int n_tests = 0;
  int n_fail  = 0;

  router_iact dut_a (
    .clk(clk), .reset(reset), .load_spad_ctrl(load_a), .r_data_glb_iact(rdata_a),
    .read_req_glb_iact(rq_a), .r_addr_glb_iact(ad_a), .w_data_spad(wd_a), .load_en_spad(le_a)
  );

  router_iact #(.A_READ_ADDR(1020)) dut_b (
    .clk(clk), .reset(reset), .load_spad_ctrl(load_b), .r_data_glb_iact(rdata_b),
    .read_req_glb_iact(rq_b), .r_addr_glb_iact(ad_b), .w_data_spad(wd_b), .load_en_spad(le_b)
  );

  // GLB model: address k holds 10+k, data one cycle after the request, junk otherwise.
  function automatic logic [15:0] glb(input logic [9:0] a);
    return 16'(a) + 16'd10;
  endfunction

  always @(posedge clk) begin
    rdata_a <= rq_a ? glb(ad_a) : 16'hDEAD;
    rdata_b <= rq_b ? glb(ad_b) : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input bit b, input string ctx, input logic erq, input logic [9:0] ead,
                               input logic ele, input logic [15:0] ewd, input bit chk_addr);
    check({ctx, " req"},   32'(b ? rq_b : rq_a), 32'(erq));
    check({ctx, " ld_en"}, 32'(b ? le_b : le_a), 32'(ele));
    check({ctx, " wdata"}, 32'(b ? wd_b : wd_a), 32'(ewd));
    if (chk_addr) check({ctx, " addr"}, 32'(b ? ad_b : ad_a), 32'(ead));
  endtask

  task automatic set_load(input bit b, input logic v);
    if (b) load_b = v;
    else   load_a = v;
  endtask

  // Called at a negedge; returns at the negedge after the starting edge (request 0 visible).
  task automatic start_burst(input bit b, input bit short_pulse);
    if (short_pulse) begin
      #4 set_load(b, 1'b1);
      #2 set_load(b, 1'b0);
      @(negedge clk);
    end else begin
      set_load(b, 1'b1);
      @(negedge clk);
      set_load(b, 1'b0);
    end
  endtask

  task automatic run_burst(input bit b, input int base, input int repulse_at, input bit short_pulse);
    logic erq, ele;
    logic [9:0] ead;
    logic [15:0] ewd;
    start_burst(b, short_pulse);
    for (int c = 0; c < 40; c++) begin
      erq = (c < 25);
      ead = 10'(base + c);
      ele = (c >= 1) && (c <= 25);
      ewd = ele ? glb(10'(base + c - 1)) : 16'd0;
      check_outputs(b, $sformatf("burst b%0d c%0d", b, c), erq, ead, ele, ewd, erq);
      if (c == repulse_at) set_load(b, 1'b1);
      else if (c == repulse_at + 1) set_load(b, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input int cycles, input string ctx);
    for (int c = 0; c < cycles; c++) begin
      check_outputs(1'b0, ctx, 1'b0, 10'd0, 1'b0, 16'd0, 1'b1);
      @(negedge clk);
    end
  endtask

  initial begin
    reset  = 1'b1;
    load_a = 1'b0;
    load_b = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs(1'b0, "reset a", 1'b0, 10'd0, 1'b0, 16'd0, 1'b1);
    check_outputs(1'b1, "reset b", 1'b0, 10'd0, 1'b0, 16'd0, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    check_idle(50, "idle50");

    // Single burst, then a second one after 10 idle cycles started by a short pulse.
    run_burst(1'b0, 0, -1, 1'b0);
    repeat (10) @(negedge clk);
    run_burst(1'b0, 0, -1, 1'b1);

    // Re-request during READ must be ignored.
    run_burst(1'b0, 0, 5, 1'b0);

    // Reset in the middle of a burst.
    start_burst(1'b0, 1'b0);
    for (int c = 0; c <= 12; c++) begin
      check("mid req", 32'(rq_a), 32'd1);
      check("mid addr", 32'(ad_a), 32'(c));
      if (c < 12) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_outputs(1'b0, "abort", 1'b0, 10'd0, 1'b0, 16'd0, 1'b1);
    @(negedge clk);
    check_idle(5, "post abort");
    run_burst(1'b0, 0, -1, 1'b0);

    // Reset wins over a simultaneous load request.
    reset  = 1'b1;
    load_a = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    load_a = 1'b0;
    check_outputs(1'b0, "rst prio", 1'b0, 10'd0, 1'b0, 16'd0, 1'b1);
    @(negedge clk);
    check_outputs(1'b0, "rst prio+1", 1'b0, 10'd0, 1'b0, 16'd0, 1'b1);

    // Held request: one burst, one idle cycle, then a fresh burst from the base.
    load_a = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 28; c++) begin
      check("hold req", 32'(rq_a), 32'((c < 25) || (c >= 26)));
      if (c < 25)       check("hold addr", 32'(ad_a), 32'(c));
      else if (c >= 26) check("hold addr", 32'(ad_a), 32'(c - 26));
      @(negedge clk);
    end
    load_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!rq_a) break;
      @(negedge clk);
    end
    check("hold drain", 32'(rq_a), 32'd0);
    repeat (3) @(negedge clk);
    check("hold drain ld_en", 32'(le_a), 32'd0);

    // Address wrap from 1023 to 0.
    run_burst(1'b1, 1020, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
